dma_bus_arbiter: RTL and testbench

//  Owns the CPU<->DMA bus handover for the XT system: turns the DMA controller's hold_request into a

---
 rtl/dma_arb_pkg.sv | 31 +++
 rtl/dma_page_register_file.sv | 63 ++++++
 rtl/dma_bus_arbiter.sv | 98 +++++++++
 tb/tb_dma_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types for the CPU<->DMA bus arbiter: handover FSM states and the
// page-register index to DMA channel map.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRelease = 2'd1,
    StGranted = 2'd2,
    StReclaim = 2'd3
  } arb_state_e;

  localparam int unsigned NumChannels = 4;

  // The XT decodes page-register ports out of channel order.
  localparam logic [1:0] Idx0Channel = 2'd0;
  localparam logic [1:0] Idx1Channel = 2'd2;
  localparam logic [1:0] Idx2Channel = 2'd3;
  localparam logic [1:0] Idx3Channel = 2'd1;

  function automatic logic [1:0] idx_to_channel(input logic [1:0] idx);
    logic [1:0] channel;
    unique case (idx)
      2'd0:    channel = Idx0Channel;
      2'd1:    channel = Idx1Channel;
      2'd2:    channel = Idx2Channel;
      default: channel = Idx3Channel;
    endcase
    return channel;
  endfunction

endpackage

// File: rtl/dma_page_register_file.sv
// Four DMA page registers with write decode and DACK-selected upper address.
// Optional readback of the registers when DMA_ARB_PAGE_READBACK_EN is defined.
module dma_page_register_file
  import dma_arb_pkg::*;
#(
  parameter int unsigned PAGE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  io_write_n,
  input  logic                  io_read_n,
  input  logic [1:0]            address_in,
  input  logic [7:0]            data_bus_in,
  input  logic [3:0]            dma_acknowledge,
  output logic [7:0]            data_bus_out,
  output logic [PAGE_WIDTH-1:0] page_address
);

  logic [PAGE_WIDTH-1:0] page_q [NumChannels];
  logic                  write_en;
  logic [1:0]            access_channel;
  logic [7:0]            unused_data;

  assign write_en       = ~chip_select_n & ~io_write_n;
  assign access_channel = idx_to_channel(address_in);
  assign unused_data    = data_bus_in;

  // Level-sensitive write: the value present on the last strobed clock wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumChannels; i++) begin
        page_q[i] <= '0;
      end
    end else if (write_en) begin
      page_q[access_channel] <= data_bus_in[PAGE_WIDTH-1:0];
    end
  end

  // Descending scan so the lowest acknowledged channel has the final say.
  always_comb begin
    page_address = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (dma_acknowledge[i]) begin
        page_address = page_q[i];
      end
    end
  end

`ifdef DMA_ARB_PAGE_READBACK_EN
  always_comb begin
    data_bus_out = '0;
    if (~chip_select_n & ~io_read_n) begin
      data_bus_out[PAGE_WIDTH-1:0] = page_q[access_channel];
    end
  end
`else
  logic unused_read_n;
  assign unused_read_n = io_read_n;
  assign data_bus_out  = 8'h00;
`endif

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU<->DMA bus handover at safe CPU bus boundaries plus DMA page registers.
// Define DMA_ARB_PAGE_READBACK_EN to make the page registers readable.
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned PAGE_WIDTH     = 4,
  parameter int unsigned MIN_CPU_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_clock,
  input  logic                  cpu_bus_idle,
  input  logic                  cpu_lock_n,
  input  logic                  hold_request,
  output logic                  hold_acknowledge,
  output logic                  cpu_bus_release,
  input  logic [3:0]            dma_acknowledge,
  input  logic                  chip_select_n,
  input  logic                  io_write_n,
  input  logic                  io_read_n,
  input  logic [1:0]            address_in,
  input  logic [7:0]            data_bus_in,
  output logic [7:0]            data_bus_out,
  output logic [PAGE_WIDTH-1:0] page_address
);

  localparam int unsigned GapWidth =
      (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;
  localparam logic [GapWidth-1:0] GapLoad = GapWidth'(MIN_CPU_CYCLES);

  arb_state_e          state_q, state_d;
  logic [GapWidth-1:0] gap_q, gap_d;
  logic                prev_cpu_clock_q;
  logic                cpu_pulse;

  assign cpu_pulse = cpu_clock & ~prev_cpu_clock_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (cpu_pulse) begin
      unique case (state_q)
        StIdle: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GapWidth'(1);
          end
          if (hold_request && cpu_bus_idle && cpu_lock_n && (gap_q == '0)) begin
            state_d = StRelease;
          end
        end
        StRelease: state_d = hold_request ? StGranted : StReclaim;
        // LOCK only gates new grants; an active grant runs to completion.
        StGranted: begin
          if (!hold_request) begin
            state_d = StReclaim;
          end
        end
        StReclaim: begin
          state_d = StIdle;
          gap_d   = GapLoad;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      gap_q            <= '0;
      prev_cpu_clock_q <= 1'b0;
      hold_acknowledge <= 1'b0;
      cpu_bus_release  <= 1'b0;
    end else begin
      state_q          <= state_d;
      gap_q            <= gap_d;
      prev_cpu_clock_q <= cpu_clock;
      hold_acknowledge <= (state_d == StGranted);
      cpu_bus_release  <= (state_d != StIdle);
    end
  end

  dma_page_register_file #(
    .PAGE_WIDTH (PAGE_WIDTH)
  ) u_page_regs (
    .clock           (clock),
    .reset           (reset),
    .chip_select_n   (chip_select_n),
    .io_write_n      (io_write_n),
    .io_read_n       (io_read_n),
    .address_in      (address_in),
    .data_bus_in     (data_bus_in),
    .dma_acknowledge (dma_acknowledge),
    .data_bus_out    (data_bus_out),
    .page_address    (page_address)
  );

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed handover/page scenarios then random
// traffic, all checked against a rule-level reference model.
module tb_dma_bus_arbiter;

  localparam int unsigned PageWidth = 4;
  localparam int unsigned MinCycles = 3;

  logic       clock, reset, cpu_clock, cpu_bus_idle, cpu_lock_n, hold_request;
  logic       hold_acknowledge, cpu_bus_release;
  logic [3:0] dma_acknowledge;
  logic       chip_select_n, io_write_n, io_read_n;
  logic [1:0] address_in;
  logic [7:0] data_bus_in, data_bus_out;
  logic [PageWidth-1:0] page_address;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: bus owner phase and page contents per channel.
  int                   m_phase;  // 0 cpu, 1 releasing, 2 dma owns, 3 reclaiming
  int                   m_gap;
  logic [PageWidth-1:0] m_page [4];
  int                   idx_ch [4] = '{0, 2, 3, 1};

  dma_bus_arbiter #(
    .PAGE_WIDTH     (PageWidth),
    .MIN_CPU_CYCLES (MinCycles)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_clock        (cpu_clock),
    .cpu_bus_idle     (cpu_bus_idle),
    .cpu_lock_n       (cpu_lock_n),
    .hold_request     (hold_request),
    .hold_acknowledge (hold_acknowledge),
    .cpu_bus_release  (cpu_bus_release),
    .dma_acknowledge  (dma_acknowledge),
    .chip_select_n    (chip_select_n),
    .io_write_n       (io_write_n),
    .io_read_n        (io_read_n),
    .address_in       (address_in),
    .data_bus_in      (data_bus_in),
    .data_bus_out     (data_bus_out),
    .page_address     (page_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PageWidth-1:0] exp_page(input logic [3:0] dack);
    for (int ch = 0; ch < 4; ch++) begin
      if (dack[ch]) return m_page[ch];
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_gap   = 0;
    for (int ch = 0; ch < 4; ch++) m_page[ch] = '0;
  endtask

  task automatic model_pulse();
    case (m_phase)
      0: begin
        if (hold_request && cpu_bus_idle && cpu_lock_n && m_gap == 0) m_phase = 1;
        if (m_gap > 0) m_gap = m_gap - 1;
      end
      1: m_phase = hold_request ? 2 : 3;
      2: if (!hold_request) m_phase = 3;
      default: begin
        m_phase = 0;
        m_gap   = MinCycles;
      end
    endcase
  endtask

  // One full cpu_clock period; exactly one rising edge is seen by the DUT.
  task automatic tick();
    @(negedge clock);
    cpu_clock = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cpu_clock = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic step(input string tag);
    tick();
    model_pulse();
    check({tag, ".hlda"}, 8'(hold_acknowledge), 8'(m_phase == 2));
    check({tag, ".release"}, 8'(cpu_bus_release), 8'(m_phase != 0));
    check({tag, ".page"}, 8'(page_address), 8'(exp_page(dma_acknowledge)));
  endtask

  task automatic page_write(input logic [1:0] idx, input logic [7:0] data);
    @(negedge clock);
    chip_select_n = 1'b0;
    io_write_n    = 1'b0;
    address_in    = idx;
    data_bus_in   = data;
    @(negedge clock);
    chip_select_n = 1'b1;
    io_write_n    = 1'b1;
    m_page[idx_ch[idx]] = data[PageWidth-1:0];
  endtask

  initial begin
    int n;
    logic [7:0] rb_exp;
    reset = 1'b1;
    cpu_clock = 1'b0;
    cpu_bus_idle = 1'b1;
    cpu_lock_n = 1'b1;
    hold_request = 1'b0;
    dma_acknowledge = 4'b0001;
    chip_select_n = 1'b1;
    io_write_n = 1'b1;
    io_read_n = 1'b1;
    address_in = 2'd0;
    data_bus_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset.hlda", 8'(hold_acknowledge), 8'h00);
    check("reset.release", 8'(cpu_bus_release), 8'h00);
    check("reset.page", 8'(page_address), 8'h00);
    check("reset.dout", data_bus_out, 8'h00);

    // Basic grant and return
    hold_request = 1'b1;
    step("t1.p1");
    check("t1.release_first", 8'(cpu_bus_release), 8'h01);
    step("t1.p2");
    check("t1.hlda_second", 8'(hold_acknowledge), 8'h01);
    hold_request = 1'b0;
    step("t1.drop1");
    step("t1.drop2");
    check("t1.release_low", 8'(cpu_bus_release), 8'h00);

    // Busy CPU bus holds off the grant
    hold_request = 1'b1;
    cpu_bus_idle = 1'b0;
    for (int i = 0; i < 5; i++) step("t2.busy");
    check("t2.no_hlda", 8'(hold_acknowledge), 8'h00);
    cpu_bus_idle = 1'b1;
    step("t2.p1");
    step("t2.p2");
    check("t2.granted", 8'(hold_acknowledge), 8'h01);

    // LOCK blocks new grants but not an active one
    hold_request = 1'b0;
    step("t3.drop1");
    step("t3.drop2");
    cpu_lock_n = 1'b0;
    hold_request = 1'b1;
    for (int i = 0; i < 6; i++) step("t3.locked");
    check("t3.no_grant", 8'(cpu_bus_release), 8'h00);
    cpu_lock_n = 1'b1;
    step("t3.p1");
    step("t3.p2");
    cpu_lock_n = 1'b0;
    step("t3.hold1");
    step("t3.hold2");
    check("t3.lock_ignored", 8'(hold_acknowledge), 8'h01);
    cpu_lock_n = 1'b1;

    // Minimum CPU gap with HRQ kept high through reclaim
    hold_request = 1'b0;
    step("t5.reclaim");
    hold_request = 1'b1;
    step("t5.idle");
    n = 0;
    do begin
      step("t5.wait");
      n++;
    end while (!cpu_bus_release && n < 20);
    check("t5.gap_pulses", 8'(n), 8'(MinCycles + 1));
    step("t5.regrant");

    // Page registers (written while granted)
    page_write(2'd0, 8'h05);
    page_write(2'd1, 8'h0A);
    page_write(2'd2, 8'h03);
    page_write(2'd3, 8'h0C);
    foreach (idx_ch[i]) begin
      dma_acknowledge = 4'b0001 << idx_ch[i];
      #1 check("t4.page_idx", 8'(page_address), 8'(exp_page(dma_acknowledge)));
    end
    dma_acknowledge = 4'b0010;
    #1 check("t4.dack0010", 8'(page_address), 8'h0C);
    dma_acknowledge = 4'b0000;
    #1 check("t4.dack0000", 8'(page_address), 8'h00);
    dma_acknowledge = 4'b0011;
    #1 check("t4.dack0011", 8'(page_address), 8'h05);
    @(negedge clock);
    chip_select_n = 1'b0;
    io_read_n = 1'b0;
    address_in = 2'd1;
`ifdef DMA_ARB_PAGE_READBACK_EN
    rb_exp = 8'(m_page[idx_ch[1]]);
`else
    rb_exp = 8'h00;
`endif
    #1 check("t4.readback", data_bus_out, rb_exp);
    @(negedge clock);
    chip_select_n = 1'b1;
    io_read_n = 1'b1;

    // Reset mid-grant
    dma_acknowledge = 4'b0001;
    step("t6.pre");
    check("t6.pre_granted", 8'(hold_acknowledge), 8'h01);
    @(negedge clock);
    reset = 1'b1;
    chip_select_n = 1'b0;
    io_read_n = 1'b0;
    #1;
    model_reset();
    check("t6.hlda", 8'(hold_acknowledge), 8'h00);
    check("t6.release", 8'(cpu_bus_release), 8'h00);
    check("t6.page", 8'(page_address), 8'h00);
    check("t6.dout", data_bus_out, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    chip_select_n = 1'b1;
    io_read_n = 1'b1;
    step("t6.after");
    check("t6.idle_restart", 8'(cpu_bus_release), 8'h01);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        page_write(2'($urandom_range(0, 3)), 8'($urandom));
      end
      hold_request    = ($urandom_range(0, 3) != 0);
      cpu_bus_idle    = ($urandom_range(0, 3) != 0);
      cpu_lock_n      = ($urandom_range(0, 7) != 0);
      dma_acknowledge = 4'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
